// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg -- shared types for the MIPS run controller.
//   state_e    : controller FSM states
//   mode_e     : run-mode encodings driven on the mode input
//   cause_e    : done_cause encodings
//   stop_cause : resolves simultaneous stop conditions into one cause
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        MODE_FREE = 2'b00,
        MODE_STEP = 2'b01,
        MODE_BP   = 2'b10,
        MODE_RSVD = 2'b11   // behaves as MODE_FREE
    } mode_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_HALT    = 3'd1,
        CAUSE_BP      = 3'd2,
        CAUSE_STALL   = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } cause_e;

    // Priority: halt > breakpoint > stall > timeout.
    function automatic cause_e stop_cause(input logic halt,
                                          input logic bp,
                                          input logic stall,
                                          input logic timeout);
        if (halt)    return CAUSE_HALT;
        if (bp)      return CAUSE_BP;
        if (stall)   return CAUSE_STALL;
        if (timeout) return CAUSE_TIMEOUT;
        return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// ---------------------------------------------------------------------------
// mips_run_ctrl_if -- control/status bundle between a host (master) and the
// run controller (slave).
//   host -> ctrl : start, step, mode, bp_en, bp_addr, pc, halt_req, clear
//   ctrl -> host : cpu_rst, cpu_en, cycle_cnt, done, done_cause
// ---------------------------------------------------------------------------
interface mips_run_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int PC_W  = 32
) ();

    logic             start;
    logic             step;
    logic [1:0]       mode;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             halt_req;
    logic             clear;

    logic             cpu_rst;
    logic             cpu_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic             done;
    logic [2:0]       done_cause;

    modport master (
        output start, step, mode, bp_en, bp_addr, pc, halt_req, clear,
        input  cpu_rst, cpu_en, cycle_cnt, done, done_cause
    );

    modport slave (
        input  start, step, mode, bp_en, bp_addr, pc, halt_req, clear,
        output cpu_rst, cpu_en, cycle_cnt, done, done_cause
    );

endinterface

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter -- up-counter that sticks at all-ones.
//   clk, rst : clock, async active-high reset (count -> 0)
//   clr_i    : synchronous clear, wins over inc_i
//   inc_i    : increment by one this cycle
//   count_o  : registered count
//   next_o   : value count_o takes if inc_i is asserted (saturated)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] count_q;

    assign next_o  = (count_q == '1) ? count_q : count_q + WIDTH'(1);
    assign count_o = count_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= next_o;
        end
    end

endmodule

// File: rtl/mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// mips_run_ctrl -- sequences reset, run, single-step and stop of a CPU core.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of mips_run_ctrl_if (start/step/mode/breakpoint/
//              pc/halt_req/clear in; cpu_rst/cpu_en/cycle_cnt/done/
//              done_cause out, all registered)
// Stop conditions are judged at the edge that ends each enabled CPU cycle,
// using pc/halt_req as seen in that cycle.
// ---------------------------------------------------------------------------
module mips_run_ctrl
    import mips_pkg::*;
#(
    parameter int RST_CYCLES  = 2,
    parameter int MAX_CYCLES  = 1500,
    parameter int CNT_W       = 32,
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic           clk,
    input  logic           rst,
    mips_run_ctrl_if.slave bus
);

    localparam int HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    cause_e             cause_q, cause_d, cause_now;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STALL_W-1:0] stall_q, stall_d, run_len;
    logic [PC_W-1:0]    last_pc_q, last_pc_d;
    logic               cpu_rst_q, cpu_rst_d;
    logic               cpu_en_q, cpu_en_d;
    logic               done_q, done_d;
    logic               cnt_clr, stop;
    logic [CNT_W-1:0]   cnt_q, cnt_next;

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .inc_i   (cpu_en_q),
        .count_o (cnt_q),
        .next_o  (cnt_next)
    );

    // stall_q == 0 means "no pc seen yet this run", so the first enabled
    // cycle starts a fresh run length of one.
    assign run_len = (stall_q == '0 || bus.pc != last_pc_q) ? STALL_W'(1)
                                                            : stall_q + STALL_W'(1);

    assign cause_now = stop_cause(bus.halt_req,
                                  bus.bp_en && mode_q == MODE_BP && bus.pc == bus.bp_addr,
                                  run_len == STALL_W'(STALL_LIMIT),
                                  cnt_next == CNT_W'(MAX_CYCLES));
    assign stop = cpu_en_q && (cause_now != CAUSE_NONE);

    // NOTE: every variable written here gets a default first, so no path
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cause_d   = cause_q;
        hold_d    = hold_q;
        stall_d   = stall_q;
        last_pc_d = last_pc_q;
        cpu_rst_d = cpu_rst_q;
        cpu_en_d  = 1'b0;
        done_d    = done_q;
        cnt_clr   = 1'b0;

        if (cpu_en_q) begin
            stall_d   = run_len;
            last_pc_d = bus.pc;
        end

        unique case (state_q)
            ST_RESET_HOLD: begin
                cpu_rst_d = 1'b1;
                if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
                    state_d   = ST_IDLE;
                    cpu_rst_d = 1'b0;
                    hold_d    = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.start) begin
                    // Mode is frozen here; later mode changes wait for the next start.
                    mode_d  = mode_e'(bus.mode);
                    stall_d = '0;
                    if (mode_e'(bus.mode) == MODE_STEP) begin
                        state_d = ST_STEP;
                    end else begin
                        state_d  = ST_RUN;
                        cpu_en_d = 1'b1;
                    end
                end
            end
            ST_RUN, ST_STEP: begin
                if (stop) begin
                    // A step pulse in the stopping cycle is dropped.
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    cause_d = cause_now;
                end else begin
                    cpu_en_d = (state_q == ST_RUN) ? 1'b1 : bus.step;
                end
            end
            ST_DONE: begin
                if (bus.clear) begin
                    state_d   = ST_RESET_HOLD;
                    cpu_rst_d = 1'b1;
                    hold_d    = '0;
                    done_d    = 1'b0;
                    cause_d   = CAUSE_NONE;
                    cnt_clr   = 1'b1;
                end
            end
            default: state_d = ST_RESET_HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RESET_HOLD;
            mode_q    <= MODE_FREE;
            cause_q   <= CAUSE_NONE;
            hold_q    <= '0;
            stall_q   <= '0;
            last_pc_q <= '0;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cause_q   <= cause_d;
            hold_q    <= hold_d;
            stall_q   <= stall_d;
            last_pc_q <= last_pc_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_en_q  <= cpu_en_d;
            done_q    <= done_d;
        end
    end

    assign bus.cpu_rst    = cpu_rst_q;
    assign bus.cpu_en     = cpu_en_q;
    assign bus.cycle_cnt  = cnt_q;
    assign bus.done       = done_q;
    assign bus.done_cause = cause_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_run_ctrl -- directed and randomized checks of mips_run_ctrl.
// Per-run pc/halt_req traces are prepared up front; the DUT consumes one
// entry per enabled cycle. Expected stop points for random traces come from
// a reference model that scans the trace with the stop rules directly.
// ---------------------------------------------------------------------------
module tb_mips_run_ctrl;

    localparam int RST_CYCLES  = 2;
    localparam int MAX_CYCLES  = 1500;
    localparam int STALL_LIMIT = 16;
    localparam int N           = 1600;

    logic clk = 1'b0;
    logic rst;

    mips_run_ctrl_if #(.CNT_W(32), .PC_W(32)) bus ();

    mips_run_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .CNT_W       (32),
        .PC_W        (32),
        .STALL_LIMIT (STALL_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] pc_seq   [N];
    logic        halt_seq [N];

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts cycles with cpu_rst high, starting at the current sample point.
    task automatic wait_hold(input string tag);
        int n = 0;
        while (bus.cpu_rst === 1'b1 && n < 20) begin
            check({tag, "_hold_en"}, bus.cpu_en, 0);
            check({tag, "_hold_done"}, bus.done, 0);
            n++;
            tick();
        end
        check({tag, "_hold_len"}, n, RST_CYCLES);
        check({tag, "_idle_cnt"}, bus.cycle_cnt, 0);
    endtask

    task automatic clear_to_idle(input string tag);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check({tag, "_clr_rst"}, bus.cpu_rst, 1);
        check({tag, "_clr_cnt"}, bus.cycle_cnt, 0);
        check({tag, "_clr_done"}, bus.done, 0);
        check({tag, "_clr_cause"}, bus.done_cause, 0);
        wait_hold(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst_cpu_rst"}, bus.cpu_rst, 1);
        check({tag, "_rst_en"}, bus.cpu_en, 0);
        check({tag, "_rst_cnt"}, bus.cycle_cnt, 0);
        check({tag, "_rst_done"}, bus.done, 0);
        check({tag, "_rst_cause"}, bus.done_cause, 0);
        tick();
        tick();
        rst = 1'b0;
        wait_hold(tag);
    endtask

    // pc advances by 4 per enabled cycle, optionally stuck at a ceiling.
    task automatic fill_linear(input logic [31:0] ceiling);
        for (int k = 0; k < N; k++) begin
            pc_seq[k]   = (32'(k) * 4 > ceiling) ? ceiling : 32'(k) * 4;
            halt_seq[k] = 1'b0;
        end
    endtask

    task automatic fill_random();
        logic [31:0] cur;
        int          freeze;
        cur    = $urandom & 32'hffff_fffc;
        freeze = 0;
        for (int k = 0; k < N; k++) begin
            pc_seq[k]   = cur;
            halt_seq[k] = 1'b0;
            if (freeze > 0) begin
                freeze--;
            end else begin
                cur = cur + 32'd4;
                if ($urandom_range(0, 39) == 0) freeze = $urandom_range(4, 24);
            end
        end
        if ($urandom_range(0, 2) != 0) halt_seq[$urandom_range(0, 600)] = 1'b1;
    endtask

    // Reference: scan the trace one enabled cycle at a time; the first
    // cycle where any stop rule holds ends the run.
    function automatic void model_run(input logic bp_active, input logic [31:0] bp_addr,
                                      output int stop_idx, output int cause);
        int same = 0;
        stop_idx = N - 1;
        cause    = 0;
        for (int k = 0; k < N; k++) begin
            if (k == 0 || pc_seq[k] != pc_seq[k-1]) same = 1;
            else same++;
            if (halt_seq[k])                           cause = 1;
            else if (bp_active && pc_seq[k] == bp_addr) cause = 2;
            else if (same >= STALL_LIMIT)               cause = 3;
            else if (k + 1 == MAX_CYCLES)               cause = 4;
            if (cause != 0) begin
                stop_idx = k;
                return;
            end
        end
    endfunction

    // Free-run / breakpoint run from IDLE. m_mid is driven on mode right
    // after start; stray clear and start pulses are injected mid-run.
    task automatic run_check(input string tag, input logic [1:0] m, input logic [1:0] m_mid,
                             input int exp_cause, input int exp_cnt);
        int idx = 0;
        int t   = 0;
        logic [31:0] cnt_at_done;
        bus.mode  = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = m_mid;
        check({tag, "_en_after_start"}, bus.cpu_en, 1);
        while (bus.done !== 1'b1 && t < MAX_CYCLES + 50) begin
            bus.clear = (t == 7);
            bus.start = (t == 9);
            if (bus.cpu_en === 1'b1 && idx < N) begin
                bus.pc       = pc_seq[idx];
                bus.halt_req = halt_seq[idx];
                idx++;
            end else begin
                bus.halt_req = 1'b0;
            end
            tick();
            t++;
        end
        bus.clear    = 1'b0;
        bus.start    = 1'b0;
        bus.halt_req = 1'b0;
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_cause"}, bus.done_cause, exp_cause);
        check({tag, "_cnt"}, bus.cycle_cnt, exp_cnt);
        check({tag, "_en_cycles"}, idx, exp_cnt);
        check({tag, "_en_dropped"}, bus.cpu_en, 0);
        cnt_at_done = bus.cycle_cnt;
        repeat (3) tick();
        check({tag, "_cause_held"}, bus.done_cause, exp_cause);
        check({tag, "_done_held"}, bus.done, 1);
        check({tag, "_cnt_held"}, bus.cycle_cnt, cnt_at_done);
        check({tag, "_en_held_low"}, bus.cpu_en, 0);
    endtask

    initial begin
        int          idx, en, rises, t, s, c;
        logic        prev;
        logic [1:0]  m;
        logic        rb_en;
        logic [31:0] rb_addr;

        bus.start    = 1'b0;
        bus.step     = 1'b0;
        bus.mode     = 2'b00;
        bus.bp_en    = 1'b0;
        bus.bp_addr  = '0;
        bus.pc       = '0;
        bus.halt_req = 1'b0;
        bus.clear    = 1'b0;

        // Power-on reset, then exactly RST_CYCLES of cpu_rst.
        do_reset("por");

        // IDLE ignores step and clear.
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        check("idle_step_en", bus.cpu_en, 0);
        check("idle_step_cnt", bus.cycle_cnt, 0);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("idle_clear_rst", bus.cpu_rst, 0);

        // Timeout; a mid-run switch to breakpoint mode must not take effect.
        fill_linear(32'hffff_fffc);
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h100;
        run_check("timeout", 2'b00, 2'b10, 4, MAX_CYCLES);
        clear_to_idle("clr_timeout");

        // Breakpoint at 0x40 with pc stepping by 4 from 0.
        bus.bp_addr = 32'h40;
        run_check("bp", 2'b10, 2'b00, 2, 17);
        clear_to_idle("clr_bp");

        // Halt and breakpoint in the same cycle: halt wins.
        halt_seq[16] = 1'b1;
        run_check("halt_bp", 2'b10, 2'b10, 1, 17);
        clear_to_idle("clr_halt_bp");

        // Reserved mode behaves as free-run: breakpoint ignored, halt at 31st cycle.
        fill_linear(32'hffff_fffc);
        halt_seq[30] = 1'b1;
        run_check("rsvd", 2'b11, 2'b11, 1, 31);
        clear_to_idle("clr_rsvd");

        // Stall: pc reaches 0x10 in the 5th cycle and stays there.
        bus.bp_en = 1'b0;
        fill_linear(32'h10);
        run_check("stall", 2'b00, 2'b00, 3, 20);
        clear_to_idle("clr_stall");

        // Single-step: three pulses five cycles apart -> three 1-cycle enables.
        fill_linear(32'hffff_fffc);
        bus.mode  = 2'b01;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        check("step_no_en_at_start", bus.cpu_en, 0);
        idx = 0; en = 0; rises = 0; prev = 1'b0;
        for (int k = 0; k < 30; k++) begin
            bus.step = (k == 2 || k == 7 || k == 12);
            if (bus.cpu_en === 1'b1) begin
                en++;
                if (!prev) rises++;
                bus.pc = pc_seq[idx];
                idx++;
            end
            prev = bus.cpu_en;
            tick();
        end
        bus.step = 1'b0;
        check("step_en_cycles", en, 3);
        check("step_en_pulses", rises, 3);
        check("step_cnt", bus.cycle_cnt, 3);
        check("step_not_done", bus.done, 0);
        do_reset("rst_after_step");

        // Step pulse in the stopping cycle is discarded.
        fill_linear(32'hffff_fffc);
        halt_seq[0] = 1'b1;
        bus.mode  = 2'b01;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        idx = 0; en = 0;
        for (int k = 0; k < 10; k++) begin
            bus.step = (k == 2 || k == 3);
            if (bus.cpu_en === 1'b1 && idx < N) begin
                en++;
                bus.pc       = pc_seq[idx];
                bus.halt_req = halt_seq[idx];
                idx++;
            end else begin
                bus.halt_req = 1'b0;
            end
            tick();
        end
        bus.step     = 1'b0;
        bus.halt_req = 1'b0;
        check("step_stop_en_cycles", en, 1);
        check("step_stop_done", bus.done, 1);
        check("step_stop_cause", bus.done_cause, 1);
        check("step_stop_cnt", bus.cycle_cnt, 1);
        clear_to_idle("clr_step_stop");

        // rst in the middle of a run: immediate reset, no done pulse.
        fill_linear(32'hffff_fffc);
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        idx = 0; t = 0;
        while (idx < 100 && t < 200) begin
            if (bus.cpu_en === 1'b1) begin
                bus.pc = pc_seq[idx];
                idx++;
            end
            tick();
            t++;
        end
        check("midrun_cnt_before_rst", bus.cycle_cnt, 100);
        check("midrun_done_before_rst", bus.done, 0);
        do_reset("midrun");

        // Randomized traces against the reference model.
        for (int r = 0; r < 6; r++) begin
            fill_random();
            case ($urandom_range(0, 2))
                0:       m = 2'b00;
                1:       m = 2'b10;
                default: m = 2'b11;
            endcase
            rb_en   = 1'($urandom_range(0, 1));
            rb_addr = pc_seq[$urandom_range(0, 800)];
            bus.bp_en   = rb_en;
            bus.bp_addr = rb_addr;
            model_run(m == 2'b10 && rb_en, rb_addr, s, c);
            run_check($sformatf("rnd%0d", r), m, 2'($urandom), c, s + 1);
            clear_to_idle($sformatf("clr_rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
